// File: rtl/adc_fifo_burst_reader.sv
// Read-side consumer of the ADC input FIFO: drains fixed-length bursts through a
// 4-deep skid buffer and presents them as a framed valid/ready stream.
module adc_fifo_burst_reader #(
    parameter int DATA_W        = 64,
    parameter int BURST_LEN     = 256,
    parameter int CNT_W         = 9,
    parameter int STALL_TIMEOUT = 1024
) (
    input  logic              adc_fifo_clk_rd,
    input  logic              rst_n,
    input  logic              fifo_rd_rdy,
    input  logic              fifo_rd_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_rd_req,
    output logic [DATA_W-1:0] pci_data,
    output logic              pci_valid,
    input  logic              pci_ready,
    output logic              pci_sop,
    output logic              pci_eop,
    output logic              burst_active,
    output logic              burst_done,
    output logic              burst_abort,
    output logic              err_timeout,
    input  logic              clr_err
);

    localparam int ST_W = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LP_BURST      = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] LP_LAST       = CNT_W'(BURST_LEN - 1);
    localparam logic [ST_W-1:0]  LP_STALL_LAST = ST_W'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DRAIN,
        S_ABORT
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rdy_d;
    logic              r_rd_fired;
    logic [CNT_W-1:0]  r_issued_cnt;
    logic [CNT_W-1:0]  r_out_cnt;
    logic [ST_W-1:0]   r_stall_cnt;
    logic [DATA_W-1:0] r_buf [0:3];
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic [2:0]        r_occ;
    logic              r_done;
    logic              r_abort;
    logic              r_err;

    logic              w_more;
    logic              w_valid;
    logic              w_pop;
    logic              w_drained;
    logic              w_set_err;
    logic [2:0]        w_occ_sum;

    assign w_more    = (r_issued_cnt < LP_BURST);
    assign w_occ_sum = r_occ + {2'b00, r_rd_fired};
    assign w_valid   = (r_occ != 3'd0);
    assign w_pop     = w_valid && pci_ready;
    assign w_drained = (r_occ == 3'd0) && !r_rd_fired;
    assign w_set_err = (r_state == S_BURST) && (w_next == S_ABORT);

    // Counting the word still in the read pipeline keeps the buffer from overflowing.
    assign fifo_rd_req = (r_state == S_BURST) && !fifo_rd_empty && w_more
                         && (w_occ_sum <= 3'd2);

    assign pci_valid    = w_valid;
    assign pci_data     = w_valid ? r_buf[r_rd_ptr] : '0;
    assign pci_sop      = w_valid && (r_out_cnt == '0);
    assign pci_eop      = w_valid && ((r_out_cnt == LP_LAST)
                          || ((r_state == S_ABORT) && (r_occ == 3'd1) && !r_rd_fired));
    assign burst_active = (r_state == S_BURST) || (r_state == S_DRAIN);
    assign burst_done   = r_done;
    assign burst_abort  = r_abort;
    assign err_timeout  = r_err;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (fifo_rd_rdy && !r_rdy_d) w_next = S_BURST;
            S_BURST: begin
                if (!w_more)
                    w_next = S_DRAIN;
                else if (fifo_rd_empty && (r_stall_cnt == LP_STALL_LAST))
                    w_next = S_ABORT;
            end
            S_DRAIN: if (w_drained) w_next = S_IDLE;
            S_ABORT: if (w_drained) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge adc_fifo_clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rdy_d    <= 1'b0;
            r_rd_fired <= 1'b0;
            r_done     <= 1'b0;
            r_abort    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rdy_d    <= fifo_rd_rdy;
            r_rd_fired <= fifo_rd_req;
            r_done     <= (r_state == S_DRAIN) && (w_next == S_IDLE);
            r_abort    <= (r_state == S_ABORT) && (w_next == S_IDLE);
            if (w_set_err)
                r_err <= 1'b1;
            else if (clr_err)
                r_err <= 1'b0;
        end
    end

    always_ff @(posedge adc_fifo_clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_cnt <= '0;
            r_out_cnt    <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_issued_cnt <= '0;
                r_out_cnt    <= '0;
            end else begin
                if (fifo_rd_req)
                    r_issued_cnt <= r_issued_cnt + CNT_W'(1);
                if (w_pop)
                    r_out_cnt <= r_out_cnt + CNT_W'(1);
            end
            if ((r_state == S_BURST) && fifo_rd_empty && w_more)
                r_stall_cnt <= r_stall_cnt + ST_W'(1);
            else
                r_stall_cnt <= '0;
        end
    end

    // Buffer bookkeeping; a reset empties it by clearing pointers and occupancy.
    always_ff @(posedge adc_fifo_clk_rd or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_occ    <= 3'd0;
        end else begin
            if (r_rd_fired)
                r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 2'd1;
            r_occ <= r_occ + {2'b00, r_rd_fired} - {2'b00, w_pop};
        end
    end

    // NOTE: storage is not reset; the valid gating on pci_data hides stale contents.
    always_ff @(posedge adc_fifo_clk_rd) begin
        if (r_rd_fired)
            r_buf[r_wr_ptr] <= fifo_q;
    end

endmodule

// File: tb/tb_adc_fifo_burst_reader.sv
// Directed bench for adc_fifo_burst_reader: FIFO model, scoreboard of expected
// stream beats, and immediate-assertion checks with a final summary line.
module tb_adc_fifo_burst_reader;

    localparam int DW = 64;
    localparam int BL = 8;
    localparam int CW = 4;
    localparam int ST = 16;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rd_rdy = 1'b0;
    logic          fifo_rd_empty;
    logic [DW-1:0] fifo_q = '0;
    logic          fifo_rd_req;
    logic [DW-1:0] pci_data;
    logic          pci_valid;
    logic          pci_ready = 1'b0;
    logic          pci_sop;
    logic          pci_eop;
    logic          burst_active;
    logic          burst_done;
    logic          burst_abort;
    logic          err_timeout;
    logic          clr_err = 1'b0;

    int checks = 0;
    int errors = 0;

    adc_fifo_burst_reader #(
        .DATA_W(DW), .BURST_LEN(BL), .CNT_W(CW), .STALL_TIMEOUT(ST)
    ) dut (
        .adc_fifo_clk_rd(clk),
        .rst_n(rst_n),
        .fifo_rd_rdy(fifo_rd_rdy),
        .fifo_rd_empty(fifo_rd_empty),
        .fifo_q(fifo_q),
        .fifo_rd_req(fifo_rd_req),
        .pci_data(pci_data),
        .pci_valid(pci_valid),
        .pci_ready(pci_ready),
        .pci_sop(pci_sop),
        .pci_eop(pci_eop),
        .burst_active(burst_active),
        .burst_done(burst_done),
        .burst_abort(burst_abort),
        .err_timeout(err_timeout),
        .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Non-showahead FIFO model: q appears one clock after a sampled rdreq.
    logic [DW-1:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_rd_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_rd_req && !fifo_rd_empty) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    beat_t exp_q [$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_load(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = DW'(first + i);
            wr_ptr++;
        end
    endtask

    task automatic expect_from(input int ptr, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.sop  = (i == 0);
            b.eop  = (i == n - 1);
            b.data = mem[ptr + i];
            exp_q.push_back(b);
        end
    endtask

    // Stream monitor: scoreboard compare, hold stability, event counters.
    int    pop_cnt = 0, done_cnt = 0, abort_cnt = 0, stall_seen = 0, valid_seen = 0;
    int    inflight = 0, max_inflight = 0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat;
    beat_t got;
    always @(negedge clk) begin
        if (!rst_n) begin
            inflight   = 0;
            prev_stall = 1'b0;
        end else begin
            got = {pci_sop, pci_eop, pci_data};
            if (prev_stall)
                check("hold_stable", {pci_valid, got}, {1'b1, prev_beat});
            if (pci_valid && pci_ready) begin
                pop_cnt++;
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check("sb_beat", got, exp_q.pop_front());
            end
            inflight = inflight + int'(fifo_rd_req) - int'(pci_valid && pci_ready);
            if (inflight > max_inflight) max_inflight = inflight;
            done_cnt   += int'(burst_done);
            abort_cnt  += int'(burst_abort);
            stall_seen += int'(burst_active && fifo_rd_empty);
            valid_seen += int'(pci_valid);
            prev_stall = pci_valid && !pci_ready;
            prev_beat  = got;
        end
    end

    function automatic logic [127:0] all_outs();
        return {fifo_rd_req, pci_valid, pci_sop, pci_eop, burst_active,
                burst_done, burst_abort, err_timeout, pci_data};
    endfunction

    logic [15:0] req_pat, val_pat, act_pat, done_pat;
    logic [3:0]  rdy_pat = 4'b1001;
    int base, d0, a0, p0, s0, v0;

    initial begin
        // Reset state
        #1 check("reset_outs", all_outs(), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_outs", all_outs(), 0);

        // 1: back-to-back burst, pci_ready high
        base = wr_ptr;
        fifo_load(16, 8);
        expect_from(base, 8);
        d0 = done_cnt;
        pci_ready = 1'b1;
        tick();
        fifo_rd_rdy = 1'b1;
        @(negedge clk);
        check("t1_idle_before_edge", fifo_rd_req, 0);
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            req_pat[n]  = fifo_rd_req;
            val_pat[n]  = pci_valid;
            act_pat[n]  = burst_active;
            done_pat[n] = burst_done;
        end
        check("t1_rdreq_pattern", req_pat, 16'h00FF);
        check("t1_valid_pattern", val_pat, 16'h03FC);
        check("t1_active_pattern", act_pat, 16'h07FF);
        check("t1_done_pattern", done_pat, 16'h0800);
        check("t1_sb_empty", exp_q.size(), 0);
        check("t1_done_once", done_cnt - d0, 1);
        tick();
        fifo_rd_rdy = 1'b0;
        tick();

        // 2: pci_ready toggling 1,0,0,1
        base = wr_ptr;
        fifo_load(16, 8);
        expect_from(base, 8);
        d0 = done_cnt;
        p0 = pop_cnt;
        max_inflight = 0;
        fifo_rd_rdy = 1'b1;
        for (int k = 0; k < 200; k++) begin
            tick();
            pci_ready = rdy_pat[k % 4];
            if (done_cnt != d0) break;
        end
        pci_ready = 1'b1;
        fifo_rd_rdy = 1'b0;
        check("t2_done_once", done_cnt - d0, 1);
        check("t2_pops", pop_cnt - p0, 8);
        check("t2_sb_empty", exp_q.size(), 0);
        check("t2_occ_bound", max_inflight <= 4, 1);
        tick();

        // 3: only 5 words available -> timeout abort, eop on last buffered word
        base = wr_ptr;
        fifo_load(16, 5);
        expect_from(base, 5);
        d0 = done_cnt;
        a0 = abort_cnt;
        p0 = pop_cnt;
        s0 = stall_seen;
        fifo_rd_rdy = 1'b1;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (err_timeout) break;
            if (pop_cnt - p0 >= 2) pci_ready = 1'b0;
        end
        check("t3_err_set", err_timeout, 1);
        check("t3_stall_cycles", stall_seen - s0, ST);
        check("t3_pops_before_abort", pop_cnt - p0, 2);
        pci_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (abort_cnt != a0) break;
        end
        check("t3_abort_once", abort_cnt - a0, 1);
        check("t3_no_done", done_cnt - d0, 0);
        check("t3_pops", pop_cnt - p0, 5);
        check("t3_sb_empty", exp_q.size(), 0);
        fifo_rd_rdy = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        check("t3_err_cleared", err_timeout, 0);

        // 6: empty FIFO, clr_err coincides with the timeout -> set wins
        a0 = abort_cnt;
        s0 = stall_seen;
        v0 = valid_seen;
        fifo_rd_rdy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            clr_err = (stall_seen - s0 == ST - 1);
            if (abort_cnt != a0) break;
        end
        clr_err = 1'b0;
        check("t6_err_set_wins", err_timeout, 1);
        check("t6_stall_cycles", stall_seen - s0, ST);
        check("t6_no_traffic", valid_seen - v0, 0);
        check("t6_abort_once", abort_cnt - a0, 1);
        fifo_rd_rdy = 1'b0;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();

        // 4: rdy held high for 40 cycles -> one burst; re-edge -> second burst
        base = wr_ptr;
        fifo_load(16, 16);
        expect_from(base, 8);
        d0 = done_cnt;
        fifo_rd_rdy = 1'b1;
        repeat (40) tick();
        check("t4_single_burst", done_cnt - d0, 1);
        check("t4_sb_empty_1", exp_q.size(), 0);
        fifo_rd_rdy = 1'b0;
        tick();
        tick();
        expect_from(base + 8, 8);
        fifo_rd_rdy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done_cnt - d0 >= 2) break;
        end
        check("t4_second_burst", done_cnt - d0, 2);
        check("t4_sb_empty_2", exp_q.size(), 0);
        fifo_rd_rdy = 1'b0;
        tick();

        // 5: reset after the 3rd word, new burst starts on the next FIFO word
        base = wr_ptr;
        fifo_load(16, 16);
        expect_from(base, 8);
        p0 = pop_cnt;
        fifo_rd_rdy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (pop_cnt - p0 >= 3) break;
        end
        check("t5_three_words", pop_cnt - p0, 3);
        rst_n = 1'b0;
        #1 check("t5_reset_outs", all_outs(), 0);
        exp_q.delete();
        repeat (3) tick();
        check("t5_reset_hold_outs", all_outs(), 0);
        expect_from(rd_ptr, 8);
        d0 = done_cnt;
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (done_cnt != d0) break;
        end
        check("t5_done_after_reset", done_cnt - d0, 1);
        check("t5_sb_empty", exp_q.size(), 0);
        fifo_rd_rdy = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_fifo_burst_reader.md
Name: adc_fifo_burst_reader

Overview:
- Read-side consumer of the ADC input FIFO. It sits between the FIFO read port (non-showahead, rdclk domain) and the PCI DMA stream.
- Waits for the FIFO "ready for read" level, then drains exactly BURST_LEN words through an internal 4-deep skid buffer.
- Presents the words as a valid/ready stream with SOP/EOP framing, and reports burst completion or abort.

Parameters:
- DATA_W, 64, FIFO q / stream data width.
- BURST_LEN, 256, words per burst (>=2).
- CNT_W, 9, width of burst counters; must satisfy 2^CNT_W > BURST_LEN.
- STALL_TIMEOUT, 1024, consecutive empty cycles in BURST before the burst is aborted.

Ports:
- adc_fifo_clk_rd  in  1  single clock for the whole block (FIFO read clock).
- rst_n  in  1  asynchronous reset, active-low.
- fifo_rd_rdy  in  1  FIFO ready-for-read level from the ADC control block.
- fifo_rd_empty  in  1  FIFO rdempty.
- fifo_q  in  DATA_W  FIFO q; valid 1 cycle after a sampled rdreq.
- fifo_rd_req  out  1  FIFO rdreq.
- pci_data  out  DATA_W  stream data.
- pci_valid  out  1  stream valid.
- pci_ready  in  1  stream ready from the PCI side.
- pci_sop  out  1  first word of burst, qualified by pci_valid.
- pci_eop  out  1  last word of burst, qualified by pci_valid.
- burst_active  out  1  high in states BURST and DRAIN.
- burst_done  out  1  1-cycle pulse after a complete burst.
- burst_abort  out  1  1-cycle pulse after an aborted burst.
- err_timeout  out  1  sticky flag, set on abort.
- clr_err  in  1  synchronous clear of err_timeout.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all counters 0; skid buffer empty; rdy_d=0; rd_fired=0.
  - All outputs are 0 during and after reset.
  - fifo_rd_req is forced 0 while rst_n=0.
  - Reset mid-burst discards buffered words; no done/abort pulse is generated.
- fifo_rd_req is combinational from registered state and counters only. It is asserted when all of the following hold:
  - state == BURST;
  - !fifo_rd_empty;
  - issued_cnt < BURST_LEN;
  - occ + rd_fired <= 2.
- Read pipeline:
  - rd_fired <= fifo_rd_req.
  - When rd_fired=1, fifo_q is pushed into the skid buffer at that edge.
  - Occupancy bound: occ + rd_fired <= 2 guarantees the buffer never overflows (max 4).
  - With pci_ready held high, throughput is 1 word/clk.
- Stream:
  - pci_valid = (occ != 0); pci_data = buffer head.
  - Pop on pci_valid & pci_ready. A simultaneous push and pop keeps occ unchanged.
  - pci_data, pci_sop and pci_eop stay stable while pci_valid & !pci_ready.
  - pci_sop = head is word 0 of the burst.
  - pci_eop = head is word BURST_LEN-1, or head is the last buffered word during an abort drain.
- State machine:
  - IDLE: issued_cnt=0, out_cnt=0. On rdy rising edge (fifo_rd_rdy & !rdy_d) -> BURST.
    - A level already high on leaving reset counts as an edge, since rdy_d resets to 0.
    - A level that stays high does not retrigger.
  - BURST:
    - issued_cnt increments on every fifo_rd_req.
    - stall_cnt increments on cycles with fifo_rd_empty and issued_cnt<BURST_LEN, and clears otherwise.
    - When issued_cnt reaches BURST_LEN -> DRAIN.
    - When stall_cnt reaches STALL_TIMEOUT-1 while empty -> ABORT_DRAIN, and set err_timeout.
  - DRAIN: no reads. When occ==0 and rd_fired==0 -> IDLE with a burst_done pulse.
  - ABORT_DRAIN: no reads. Deliver the already-buffered words; the last one carries pci_eop. When the buffer is empty -> IDLE with a burst_abort pulse.
    - If no words were delivered at all, no stream traffic occurs.
- out_cnt increments per pop. pci_eop on a normal burst occurs exactly when out_cnt==BURST_LEN-1.
- err_timeout: clr_err clears it. If clr_err and a set condition occur in the same cycle, set wins.
- An rdy rising edge seen while not in IDLE is ignored. rdy_d tracks the input every cycle.

Test Plan (BURST_LEN=8, STALL_TIMEOUT=16, FIFO model preloaded with 0x10..0x1F):
- Rising edge sampled on fifo_rd_rdy at edge E0, pci_ready=1 -> fifo_rd_req high for 8 consecutive cycles starting after E0; pci_valid rises after E2; words 0x10..0x17 delivered back-to-back with sop on 0x10 and eop on 0x17; burst_done pulses once; then IDLE.
- pci_ready toggles 1,0,0,1 repeating -> the same 8 words in order with no loss or duplication; occ never exceeds 4; data held stable during stalls.
- FIFO holds only 5 words, no more writes -> 0x10..0x14 delivered, eop on 0x14; after 16 empty cycles burst_abort pulses and err_timeout=1; clr_err then clears it.
- fifo_rd_rdy held high for 40 cycles -> exactly one burst; rdy falls and rises again -> second burst with words 0x18..0x1F.
- rst_n asserted after the 3rd word -> outputs 0 immediately; after release with rdy high, a new burst starts and sop lands on the next FIFO word.
- clr_err asserted in the same cycle as a timeout -> err_timeout=1.
